// File: rtl/gamepad_poll_ctrl.sv
// gamepad_poll_ctrl: latches and clocks a SNES-style serial pad, publishing an active-high snapshot per poll
module gamepad_poll_ctrl #(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150,
  parameter int NUM_BITS     = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pad_data,
  output logic                pad_latch,
  output logic                pad_clk,
  output logic                busy,
  output logic                data_valid,
  output logic [NUM_BITS-1:0] buttons,
  output logic                present
);
  localparam int CW = $clog2(LATCH_CYCLES > HALF_CYCLES ? LATCH_CYCLES : HALF_CYCLES) + 1;
  localparam int BW = $clog2(NUM_BITS + 1);
  typedef enum logic [2:0] {IDLE, LATCH, HOLD, LOW, HIGH, DONE} state_e;
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [NUM_BITS-1:0] shift_q, shift_d, buttons_q, buttons_d;
  logic [NUM_BITS:0]   shift_w;
  logic [1:0]          sync_q;
  logic                pad_latch_q, pad_latch_d, pad_clk_q, pad_clk_d, busy_q, busy_d;
  logic                dv_q, dv_d, present_q, present_d;
  logic                lat_end, half_end, sample, last_bit;
  assign lat_end  = cnt_q == CW'(LATCH_CYCLES - 1);
  assign half_end = cnt_q == CW'(HALF_CYCLES - 1);
  assign sample   = (state_q == HOLD || state_q == HIGH) && half_end;
  assign last_bit = state_q == HOLD ? NUM_BITS == 1 : bit_cnt_q == BW'(NUM_BITS - 1);
  assign shift_w  = {shift_q, sync_q[1]};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '1;
      buttons_q   <= '0;
      sync_q      <= 2'b11;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
      busy_q      <= 1'b0;
      dv_q        <= 1'b0;
      present_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      buttons_q   <= buttons_d;
      sync_q      <= {sync_q[0], pad_data};
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      busy_q      <= busy_d;
      dv_q        <= dv_d;
      present_q   <= present_d;
    end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       state_d = start ? LATCH : IDLE;
      LATCH:      state_d = lat_end ? HOLD : LATCH;
      HOLD, HIGH: state_d = !half_end ? state_q : last_bit ? DONE : LOW;
      LOW:        state_d = half_end ? HIGH : LOW;
      default:    state_d = IDLE;
    endcase
  end
  // Outputs are registered copies of the next state, so pad pins never glitch.
  always_comb begin
    cnt_d       = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CW'(1);
    bit_cnt_d   = state_q == IDLE ? '0 : !sample ? bit_cnt_q : state_q == HOLD ? BW'(1) : bit_cnt_q + BW'(1);
    shift_d     = sample ? shift_w[NUM_BITS-1:0] : shift_q;
    pad_latch_d = state_d == LATCH;
    pad_clk_d   = state_d != LOW;
    busy_d      = state_d != IDLE;
    dv_d        = state_q == DONE;
    present_d   = dv_d ? shift_q != '1 : present_q;
    buttons_d   = dv_d ? ~shift_q : buttons_q;
  end
  assign pad_latch  = pad_latch_q;
  assign pad_clk    = pad_clk_q;
  assign busy       = busy_q;
  assign data_valid = dv_q;
  assign buttons    = buttons_q;
  assign present    = present_q;
endmodule

// File: tb/tb_gamepad_poll_ctrl.sv
// tb_gamepad_poll_ctrl: random polls against a behavioural pad and a rule-level snapshot/timing model
module tb_gamepad_poll_ctrl;
  localparam int L = 4, H = 2, N = 12;
  localparam int LAT = L + H * (2 * N - 1) + 1;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start1 = 1'b0;
  logic pad_data, pad_latch, pad_clk, busy, data_valid, present;
  logic [N-1:0] buttons;
  logic pad_latch1, pad_clk1, busy1, dv1, present1;
  logic [0:0] buttons1;
  logic [N-1:0] pad_raw = '1;
  int pad_idx = 0;
  int n_chk = 0, n_pass = 0;
  int latch_hi = 0, latch_rise = 0, low_pulses = 0, bad_width = 0, low_run = 0;
  int dv_cnt = 0, clk1_low = 0;
  logic latch_prev = 1'b0;

  always #5 clk = ~clk;

  gamepad_poll_ctrl #(.LATCH_CYCLES(L), .HALF_CYCLES(H), .NUM_BITS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .pad_data(pad_data), .pad_latch(pad_latch),
    .pad_clk(pad_clk), .busy(busy), .data_valid(data_valid), .buttons(buttons), .present(present));

  gamepad_poll_ctrl #(.LATCH_CYCLES(L), .HALF_CYCLES(H), .NUM_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .pad_data(1'b0), .pad_latch(pad_latch1),
    .pad_clk(pad_clk1), .busy(busy1), .data_valid(dv1), .buttons(buttons1), .present(present1));

  // Pad: latch reloads to the first button, each clock pulse presents the next one.
  always @(posedge pad_latch, negedge pad_clk) pad_idx = pad_latch ? 0 : pad_idx + 1;
  assign pad_data = (pad_idx < N) ? pad_raw[N-1-pad_idx] : 1'b0;

  always @(negedge clk) begin
    if (pad_latch) latch_hi++;
    if (pad_latch && !latch_prev) latch_rise++;
    latch_prev = pad_latch;
    if (data_valid) dv_cnt++;
    if (!pad_clk1) clk1_low++;
    if (!pad_clk) low_run++;
    else if (low_run != 0) begin
      low_pulses++;
      if (low_run != H) bad_width++;
      low_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pressed buttons read low; a pad reporting nothing but highs is treated as absent.
  function automatic logic [N-1:0] exp_buttons(input logic [N-1:0] raw);
    logic [N-1:0] b = '0;
    if (raw == {N{1'b1}}) return '0;
    for (int i = 0; i < N; i++) b[i] = (raw[i] == 1'b0);
    return b;
  endfunction

  task automatic poll(input logic [N-1:0] raw, input string tag);
    int e, lh0, lp0, bw0;
    logic held;
    logic [N-1:0] prev;
    pad_raw = raw;
    @(negedge clk);
    lh0 = latch_hi; lp0 = low_pulses; bw0 = bad_width; prev = buttons; held = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e = 0;
    do begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (!data_valid && buttons !== prev) held = 1'b0;
    end while (!data_valid && e < 500);
    chk({tag, " latency"}, e, LAT);
    chk({tag, " buttons"}, buttons, exp_buttons(raw));
    chk({tag, " present"}, present, raw != {N{1'b1}});
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " held"}, held, 1'b1);
    chk({tag, " latch_len"}, latch_hi - lh0, L);
    chk({tag, " clk_pulses"}, low_pulses - lp0, N - 1);
    chk({tag, " clk_width"}, bad_width - bw0, 0);
  endtask

  initial begin
    int e, polls, t, d0, r0, lh0, lp0, bw0, c0;
    logic [N-1:0] raw;
    repeat (3) @(negedge clk);
    chk("rst pad_latch", pad_latch, 1'b0);
    chk("rst pad_clk", pad_clk, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst data_valid", data_valid, 1'b0);
    chk("rst buttons", buttons, '0);
    chk("rst present", present, 1'b0);
    chk("rst1 pad_clk", pad_clk1, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    poll(12'h7FF, "b_pressed");
    poll(12'hFFF, "absent");
    poll(12'hAAA, "alt");
    poll(12'h000, "all");
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      poll(12'($urandom), "rand");
    end
    // Start held high: back-to-back polls, none restarted while busy.
    raw = 12'($urandom);
    pad_raw = raw;
    @(negedge clk);
    d0 = dv_cnt; r0 = latch_rise; lh0 = latch_hi; lp0 = low_pulses; bw0 = bad_width;
    start = 1'b1;
    repeat (200) @(negedge clk);
    start = 1'b0;
    repeat (70) @(negedge clk);
    polls = 0;
    t = 0;
    while (t < 200) begin polls++; t += LAT + 1; end
    chk("b2b valid", dv_cnt - d0, polls);
    chk("b2b latches", latch_rise - r0, polls);
    chk("b2b latch_len", latch_hi - lh0, polls * L);
    chk("b2b clk_pulses", low_pulses - lp0, polls * (N - 1));
    chk("b2b clk_width", bad_width - bw0, 0);
    chk("b2b buttons", buttons, exp_buttons(raw));
    // Reset mid-poll aborts cleanly.
    poll(12'h5A5, "pre_rst");
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #2 reset = 1'b1;
    d0 = dv_cnt;
    #1;
    chk("abort pad_latch", pad_latch, 1'b0);
    chk("abort pad_clk", pad_clk, 1'b1);
    chk("abort busy", busy, 1'b0);
    chk("abort buttons", buttons, '0);
    chk("abort present", present, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort no_valid", dv_cnt - d0, 0);
    poll(12'hF0F, "post_rst");
    // Single-bit variant: HOLD sample goes straight to DONE.
    @(negedge clk);
    c0 = clk1_low;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    e = 0;
    do begin
      @(posedge clk);
      e++;
      @(negedge clk);
    end while (!dv1 && e < 100);
    chk("n1 latency", e, L + H + 1);
    chk("n1 buttons", buttons1, 1'b1);
    chk("n1 present", present1, 1'b1);
    chk("n1 clk_low", clk1_low - c0, 0);
    chk("n1 busy", busy1, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
